// File: rtl/pixel_window_3x3.sv
// pixel_window_3x3: RGB565 pixel stream to 3x3 grey sliding window using two line buffers.
// Define PIXEL_WINDOW_GRAY_CONV_EN for luma conversion; otherwise grey = pixel_in[7:0].
module pixel_window_3x3 #(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pixel_in,
    input  logic        pixel_valid,
    input  logic        frame_start,
    output logic [71:0] window,
    output logic        window_valid,
    output logic [9:0]  center_x,
    output logic [9:0]  center_y,
    output logic        frame_done
);

    localparam int unsigned AW     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [9:0]  X_LAST = 10'(IMG_WIDTH - 1);
    localparam logic [9:0]  Y_LAST = 10'(IMG_HEIGHT - 1);

    typedef enum logic {StIdle, StActive} state_t;

    state_t                 state_q;
    logic [9:0]             x_q, y_q;
    logic [9:0]             x_cur, y_cur;
    logic                   accept, win_en, last_px;
    logic [7:0]             grey, top_px, mid_px;
    logic [AW-1:0]          col;
    logic [2:0][2:0][7:0]   sr_q, sr_d;
    logic [71:0]            window_d;

    // Line buffers: line1 holds row y-1, line2 holds row y-2. Contents are never reset.
    logic [7:0] line1 [IMG_WIDTH];
    logic [7:0] line2 [IMG_WIDTH];

`ifdef PIXEL_WINDOW_GRAY_CONV_EN
    logic [7:0]  r8, g8, b8;
    logic [15:0] luma_sum;
    logic        unused_luma;

    assign r8 = {pixel_in[15:11], pixel_in[15:13]};
    assign g8 = {pixel_in[10:5], pixel_in[10:9]};
    assign b8 = {pixel_in[4:0], pixel_in[4:2]};
    assign luma_sum = 16'd77 * {8'd0, r8} + 16'd150 * {8'd0, g8} + 16'd29 * {8'd0, b8};
    assign grey = luma_sum[15:8];
    assign unused_luma = ^luma_sum[7:0];
`else
    logic unused_hi;

    assign grey = pixel_in[7:0];
    assign unused_hi = ^pixel_in[15:8];
`endif

    // A frame_start pulse restarts the frame at (0,0), even for a pixel in the same cycle.
    assign x_cur   = frame_start ? 10'd0 : x_q;
    assign y_cur   = frame_start ? 10'd0 : y_q;
    assign accept  = pixel_valid && (frame_start || (state_q == StActive));
    assign win_en  = accept && (x_cur >= 10'd2) && (y_cur >= 10'd2);
    assign last_px = accept && (x_cur == X_LAST) && (y_cur == Y_LAST);

    assign col    = x_cur[AW-1:0];
    assign top_px = line2[col];
    assign mid_px = line1[col];

    always_ff @(posedge clk) begin
        if (accept) begin
            line1[col] <= grey;
            line2[col] <= mid_px;
        end
    end

    // sr_q[row][col]: row 0 is y-2, col 0 is the oldest column (x-2).
    always_comb begin
        sr_d     = sr_q;
        window_d = '0;
        for (int r = 0; r < 3; r++) begin
            sr_d[r][0] = sr_q[r][1];
            sr_d[r][1] = sr_q[r][2];
        end
        sr_d[0][2] = top_px;
        sr_d[1][2] = mid_px;
        sr_d[2][2] = grey;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                window_d[71 - 8 * (3 * r + c) -: 8] = sr_d[r][c];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            x_q          <= '0;
            y_q          <= '0;
            sr_q         <= '0;
            window       <= '0;
            window_valid <= 1'b0;
            center_x     <= '0;
            center_y     <= '0;
            frame_done   <= 1'b0;
        end else begin
            window_valid <= win_en;
            frame_done   <= last_px;

            if (accept) begin
                sr_q <= sr_d;
                if (last_px) begin
                    x_q <= '0;
                    y_q <= '0;
                end else if (x_cur == X_LAST) begin
                    x_q <= '0;
                    y_q <= y_cur + 10'd1;
                end else begin
                    x_q <= x_cur + 10'd1;
                    y_q <= y_cur;
                end
            end else if (frame_start) begin
                x_q <= '0;
                y_q <= '0;
            end

            if (last_px) begin
                state_q <= StIdle;
            end else if (frame_start) begin
                state_q <= StActive;
            end

            if (win_en) begin
                window   <= window_d;
                center_x <= x_cur - 10'd1;
                center_y <= y_cur - 10'd1;
            end
        end
    end

endmodule

// File: doc/pixel_window_3x3.md
PIXEL_WINDOW_3X3 -- requirements
Module: pixel_window_3x3

Interface
REQ-001 Parameter IMG_WIDTH, default 640, active pixels per line (range 4..1024).
REQ-002 Parameter IMG_HEIGHT, default 480, active lines per frame (range 3..1024).
REQ-003 clk  input  1  pixel-stream clock; all logic is clocked on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 pixel_in  input  16  RGB565 pixel from the camera interface, {R[4:0],G[5:0],B[4:0]}.
REQ-006 pixel_valid  input  1  pixel_in is valid this cycle; no backpressure.
REQ-007 frame_start  input  1  single-cycle pulse marking the start of a frame.
REQ-008 window  output  72  3x3 grey window, row-major: [71:64] = top-left (row y-2, col x-2), [7:0] = bottom-right (current pixel).
REQ-009 window_valid  output  1  window, center_x and center_y are valid this cycle.
REQ-010 center_x  output  10  column of the window centre.
REQ-011 center_y  output  10  row of the window centre.
REQ-012 frame_done  output  1  single-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-013 FSM states: IDLE and ACTIVE; IDLE ignores pixel_valid.
REQ-014 frame_start in any state: x and y counters cleared to 0, FSM enters ACTIVE next cycle.
REQ-015 frame_start and pixel_valid in the same cycle: that pixel is accepted as pixel (0,0).
REQ-016 Each accepted pixel in ACTIVE advances x; x wraps from IMG_WIDTH-1 to 0 and increments y.
REQ-017 Grey conversion: r8={R,R[4:2]}, g8={G,G[5:4]}, b8={B,B[4:2]}; grey=(77*r8+150*g8+29*b8)>>8, with an 16-bit intermediate sum and no rounding.
REQ-018 Two line buffers, each IMG_WIDTH x 8, hold the grey values of rows y-1 and y-2. At column x the buffer is read before it is written.
REQ-019 A 3x3 shift register shifts one column per accepted pixel. Its new column is {row y-2, row y-1, current}.
REQ-020 window_valid is asserted exactly 1 cycle after an accepted pixel with x>=2 and y>=2; there is no border padding.
REQ-021 With window_valid asserted, center_x = x-1 and center_y = y-1 of the triggering pixel.
REQ-022 An accepted pixel at (IMG_WIDTH-1, IMG_HEIGHT-1) causes:
- a frame_done pulse 1 cycle later, coincident with the final window_valid;
- a return of the FSM to IDLE.
REQ-023 Outputs are registered; window, center_x and center_y hold their values when window_valid is low.
REQ-024 Cycles without pixel_valid in ACTIVE change no state.

Reset
REQ-025 While reset_n is low, the FSM is in IDLE and the counters and shift registers are 0.
REQ-026 While reset_n is low, window, window_valid, center_x, center_y and frame_done are all 0.
REQ-027 Line-buffer contents are not reset. Windows from a frame never depend on a previous frame, because of REQ-020.
REQ-028 Reset asserted mid-frame aborts the frame. No frame_done is issued, and processing resumes only after the next frame_start.

Configuration
REQ-029 With PIXEL_WINDOW_GRAY_CONV_EN defined, grey values are computed per REQ-017.
REQ-030 Without PIXEL_WINDOW_GRAY_CONV_EN, grey = pixel_in[7:0], no multipliers are instantiated, and latency is unchanged.

Verification
REQ-031 GRAY_CONV_EN on: pixel_in 16'hFFFF -> grey 255; pixel_in 16'hF800 -> grey 76; pixel_in 16'h0000 -> grey 0.
REQ-032 IMG_WIDTH=4, IMG_HEIGHT=3, GRAY_CONV_EN off, pixel_in[7:0]=0..11 in order:
- window_valid pulses twice;
- first window {0,1,2,4,5,6,8,9,10}, centre (1,1);
- second window {1,2,3,5,6,7,9,10,11}, centre (2,1);
- frame_done coincides with the second pulse.
REQ-033 Same stream with a 3-cycle pixel_valid gap after every pixel -> identical windows and centres, with window_valid 1 cycle after pixels 10 and 11.
REQ-034 frame_start asserted after pixel 6, then 12 fresh pixels 20..31 -> first window {20,21,22,24,25,26,28,29,30}, with no window containing 0..6.
REQ-035 reset_n pulsed low after pixel 9, then a new frame -> all outputs 0 during reset, no frame_done for the aborted frame, and the new frame matches REQ-032.
REQ-036 Pixels presented before any frame_start -> no window_valid and no frame_done.
